// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared widths and opcodes for the two-port BRAM arbiter
package bram_arb_pkg;
  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 16;
  localparam int REQ_ID_W = 1;
  typedef enum logic {OP_READ = 1'b0, OP_WRITE = 1'b1} op_e;
endpackage

// File: rtl/blk_mem_gen_0.sv
// blk_mem_gen_0: single-port read-first BRAM model with configurable output latency
//   clka : clock
//   wea, addra, dina : write enable, address, write data
//   douta : read data, READ_LATENCY edges after addra is sampled
module blk_mem_gen_0 #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic              clka,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta
);
  localparam int PW = READ_LATENCY * DATA_W;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [PW-1:0] pipe;
  always_ff @(posedge clka) begin
    if (wea) mem[addra] <= dina;
    pipe <= (pipe << DATA_W) | PW'(mem[addra]);
  end
  assign douta = pipe[PW-1 -: DATA_W];
endmodule

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin grant with pointer to the next favoured requester
//   clk, rst_n : clock, async active-low reset
//   valid      : request lines
//   grant      : one-hot grant (combinational)
//   gnt_any    : any grant this cycle
//   gnt_id     : index of the granted requester
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  output logic [1:0] grant,
  output logic       gnt_any,
  output logic       gnt_id
);
  logic rr_ptr;
  always_comb begin
    gnt_any = |valid;
    gnt_id = &valid ? rr_ptr : valid[1];
    grant = gnt_any ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_ptr <= 1'b0;
    else if (gnt_any) rr_ptr <= ~gnt_id;
endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin sharing of one single-port BRAM between two requesters
//   clk, rst_n              : clock (also BRAM clka), async active-low reset
//   req_valid/ready/we      : per-requester handshake and opcode
//   req_addr/req_wdata      : per-requester address and write data
//   rsp_valid[i]/rsp_rdata  : read response pulse for requester i, shared data
//   mem_addr/din/we/dout    : registered BRAM port, BRAM read data
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_we,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  output logic [1:0]             rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_din,
  output logic                   mem_we,
  input  logic [DATA_W-1:0]      mem_dout
);
  logic gnt_any, gnt_id;
  logic [READ_LATENCY:0] tag_v;
  logic [READ_LATENCY:0][REQ_ID_W-1:0] tag_id;
  rr_arbiter_2 u_rr (
    .clk(clk),
    .rst_n(rst_n),
    .valid(req_valid),
    .grant(req_ready),
    .gnt_any(gnt_any),
    .gnt_id(gnt_id)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_din <= '0;
      tag_v <= '0;
      tag_id <= '0;
    end else begin
      mem_we <= gnt_any && req_we[gnt_id] == OP_WRITE;
      if (gnt_any) begin
        mem_addr <= req_addr[gnt_id];
        mem_din <= req_wdata[gnt_id];
      end
      tag_v <= {tag_v[READ_LATENCY-1:0], gnt_any && req_we[gnt_id] == OP_READ};
      tag_id <= {tag_id[READ_LATENCY-1:0], REQ_ID_W'(gnt_id)};
    end
  assign rsp_valid = tag_v[READ_LATENCY] ? (tag_id[READ_LATENCY] != '0 ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_rdata = mem_dout;
endmodule

// File: tb/tb_bram_port_arbiter.sv
module tb_bram_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;
  logic [1:0] req_valid = '0;
  logic [1:0] req_we = '0;
  logic [1:0][5:0] req_addr = '0;
  logic [1:0][15:0] req_wdata = '0;
  logic [1:0] ready_a, ready_b, rv_a, rv_b;
  logic [15:0] rd_a, rd_b, din_a, din_b, dout_a, dout_b;
  logic [5:0] addr_a, addr_b;
  logic we_a, we_b;

  bram_port_arbiter #(.READ_LATENCY(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_a), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv_a), .rsp_rdata(rd_a),
    .mem_addr(addr_a), .mem_din(din_a), .mem_we(we_a), .mem_dout(dout_a)
  );
  blk_mem_gen_0 #(.READ_LATENCY(1)) mem_a (
    .clka(clk), .wea(we_a), .addra(addr_a), .dina(din_a), .douta(dout_a)
  );
  bram_port_arbiter #(.READ_LATENCY(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_b), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv_b), .rsp_rdata(rd_b),
    .mem_addr(addr_b), .mem_din(din_b), .mem_we(we_b), .mem_dout(dout_b)
  );
  blk_mem_gen_0 #(.READ_LATENCY(2)) mem_b (
    .clka(clk), .wea(we_b), .addra(addr_b), .dina(din_b), .douta(dout_b)
  );

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  logic [15:0] mdata [64];
  logic mknown [64];
  logic pv [2][8];
  logic pid [2][8];
  logic [15:0] pd [2][8];
  logic pk [2][8];
  logic rr, pw_v, exp_we, g_any, g_id;
  logic [5:0] pw_a, exp_addr;
  logic [15:0] pw_d, exp_din;
  logic [1:0] hold;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic drive(input int p, input logic v, input logic we, input logic [5:0] a, input logic [15:0] d);
    req_valid[p[0]] = v;
    req_we[p[0]] = we;
    req_addr[p[0]] = a;
    req_wdata[p[0]] = d;
  endtask

  task automatic idle();
    drive(0, 1'b0, 1'b0, 6'd0, 16'h0);
    drive(1, 1'b0, 1'b0, 6'd0, 16'h0);
  endtask

  // Per-cycle compare plus model update; the model commits the grant of the coming edge.
  task automatic tick();
    logic [1:0] erv;
    int slot;
    int s;
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_mem_we_a", 16'(we_a), 16'h0);
      chk("rst_mem_we_b", 16'(we_b), 16'h0);
      chk("rst_mem_addr_a", 16'(addr_a), 16'h0);
      chk("rst_mem_din_a", din_a, 16'h0);
      chk("rst_rsp_valid_a", 16'(rv_a), 16'h0);
      chk("rst_rsp_valid_b", 16'(rv_b), 16'h0);
      for (int k = 0; k < 8; k++) begin
        pv[0][k] = 1'b0;
        pv[1][k] = 1'b0;
      end
      rr = 1'b0;
      pw_v = 1'b0;
      exp_we = 1'b0;
      exp_addr = '0;
      exp_din = '0;
      g_any = 1'b0;
      g_id = 1'b0;
    end else begin
      slot = cyc % 8;
      for (int i = 0; i < 2; i++) begin
        erv = pv[i][slot] ? (pid[i][slot] ? 2'b10 : 2'b01) : 2'b00;
        chk($sformatf("rsp_valid_%0d", i), 16'(i == 0 ? rv_a : rv_b), 16'(erv));
        if (pv[i][slot] && pk[i][slot])
          chk($sformatf("rsp_rdata_%0d", i), i == 0 ? rd_a : rd_b, pd[i][slot]);
        pv[i][slot] = 1'b0;
      end
      chk("mem_we_a", 16'(we_a), 16'(exp_we));
      chk("mem_we_b", 16'(we_b), 16'(exp_we));
      chk("mem_addr_a", 16'(addr_a), 16'(exp_addr));
      chk("mem_addr_b", 16'(addr_b), 16'(exp_addr));
      chk("mem_din_a", din_a, exp_din);
      chk("mem_din_b", din_b, exp_din);
      if (pw_v) begin
        mdata[pw_a] = pw_d;
        mknown[pw_a] = 1'b1;
        pw_v = 1'b0;
      end
      g_any = req_valid != 2'b00;
      g_id = req_valid == 2'b11 ? rr : req_valid == 2'b10;
      erv = g_any ? (g_id ? 2'b10 : 2'b01) : 2'b00;
      chk("req_ready_a", 16'(ready_a), 16'(erv));
      chk("req_ready_b", 16'(ready_b), 16'(erv));
      if (g_any) begin
        rr = !g_id;
        exp_we = req_we[g_id];
        exp_addr = req_addr[g_id];
        exp_din = req_wdata[g_id];
        if (req_we[g_id]) begin
          pw_v = 1'b1;
          pw_a = req_addr[g_id];
          pw_d = req_wdata[g_id];
        end else
          for (int i = 0; i < 2; i++) begin
            s = (cyc + 2 + i) % 8;
            pv[i][s] = 1'b1;
            pid[i][s] = g_id;
            pd[i][s] = mdata[req_addr[g_id]];
            pk[i][s] = mknown[req_addr[g_id]];
          end
      end else
        exp_we = 1'b0;
    end
    cyc++;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc1();
    tick();
    adv();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mdata[i] = '0;
      mknown[i] = 1'b0;
    end
    hold = '0;
    tick();
    chk("rst_req_ready_a", 16'(ready_a), 16'h0);
    adv();
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      drive(0, 1'b1, 1'b1, 6'(i), 16'h1000 + 16'(i));
      cyc1();
    end
    // write then read back on port 0
    drive(0, 1'b1, 1'b1, 6'd2, 16'h3f80);
    cyc1();
    drive(0, 1'b1, 1'b0, 6'd2, 16'h0);
    cyc1();
    idle();
    cyc1();
    tick();
    chk("s1_rsp_valid_a", 16'(rv_a), 16'h1);
    chk("s1_rdata_a", rd_a, 16'h3f80);
    adv();
    tick();
    chk("s1_rsp_valid_b", 16'(rv_b), 16'h1);
    chk("s1_rdata_b", rd_b, 16'h3f80);
    adv();
    rst_n = 1'b0;
    cyc1();
    cyc1();
    rst_n = 1'b1;
    // continuous contention alternates grants and responses
    drive(0, 1'b1, 1'b0, 6'd1, 16'h0);
    drive(1, 1'b1, 1'b0, 6'd5, 16'h0);
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("s2_ready", 16'(ready_a), j % 2 == 1 ? 16'h2 : 16'h1);
      if (j >= 2) begin
        chk("s2_rsp_valid", 16'(rv_a), j % 2 == 1 ? 16'h2 : 16'h1);
        chk("s2_rdata", rd_a, j % 2 == 1 ? 16'h1005 : 16'h1001);
      end
      adv();
    end
    idle();
    repeat (3) cyc1();
    // read-before-write on addr 63 in the same cycle
    drive(0, 1'b1, 1'b0, 6'd63, 16'h0);
    drive(1, 1'b1, 1'b1, 6'd63, 16'hbeef);
    tick();
    chk("s3_ready_first", 16'(ready_a), 16'h1);
    adv();
    drive(0, 1'b0, 1'b0, 6'd0, 16'h0);
    tick();
    chk("s3_ready_write", 16'(ready_a), 16'h2);
    adv();
    drive(0, 1'b1, 1'b0, 6'd63, 16'h0);
    drive(1, 1'b0, 1'b0, 6'd0, 16'h0);
    tick();
    chk("s3_old_valid", 16'(rv_a), 16'h1);
    chk("s3_old_data", rd_a, 16'h103f);
    adv();
    idle();
    cyc1();
    tick();
    chk("s3_new_valid", 16'(rv_a), 16'h1);
    chk("s3_new_data", rd_a, 16'hbeef);
    adv();
    // lone requester 1, then contention favours 0
    for (int j = 0; j < 8; j++) begin
      drive(1, 1'b1, 1'b0, 6'($urandom_range(0, 63)), 16'h0);
      tick();
      chk("s4_p1_only", 16'(ready_a), 16'h2);
      adv();
    end
    drive(0, 1'b1, 1'b0, 6'd3, 16'h0);
    drive(1, 1'b1, 1'b0, 6'd4, 16'h0);
    tick();
    chk("s4_contend_p0", 16'(ready_a), 16'h1);
    adv();
    drive(0, 1'b0, 1'b0, 6'd0, 16'h0);
    cyc1();
    idle();
    repeat (3) cyc1();
    // reset one cycle after a read accept, with a write just accepted
    drive(0, 1'b1, 1'b0, 6'd1, 16'h0);
    cyc1();
    drive(0, 1'b0, 1'b0, 6'd0, 16'h0);
    drive(1, 1'b1, 1'b1, 6'd7, 16'h7777);
    cyc1();
    rst_n = 1'b0;
    idle();
    #1;
    chk("s5_async_mem_we", 16'(we_a), 16'h0);
    chk("s5_rsp_dropped", 16'(rv_a), 16'h0);
    cyc1();
    cyc1();
    rst_n = 1'b1;
    drive(0, 1'b1, 1'b0, 6'd7, 16'h0);
    drive(1, 1'b1, 1'b0, 6'd8, 16'h0);
    tick();
    chk("s5_first_grant_p0", 16'(ready_a), 16'h1);
    adv();
    cyc1();
    idle();
    repeat (4) cyc1();
    // randomized traffic, requests held until accepted
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 2; p++)
        if (!hold[p]) begin
          drive(p, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                $urandom_range(0, 7) == 0 ? 6'd63 : 6'($urandom_range(0, 7)), 16'($urandom));
          hold[p] = req_valid[p];
        end
      tick();
      for (int p = 0; p < 2; p++)
        if (g_any && g_id == p[0]) hold[p] = 1'b0;
      adv();
    end
    idle();
    repeat (5) cyc1();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
